dma_mc_ctrl_fsm: RTL and testbench
==================================

// Module: dma_mc_ctrl_fsm
// PURPOSE
//  Multi-channel DMA control FSM: N_CH independent channel FSMs, each launching one rd/wr streamer pair
//  and tracking outstanding AXI transactions. Adds per-channel abort, watchdog timeout and explicit done-ack.
//  Provides a shared first-error capture register with an interrupt. Sits between the CSR block and the
//  per-channel streamers / AXI I/F.
// PARAMETERS
//  N_CH    4   number of channels (1..16)
//  ADDR_W  32  error address width
//  TMO_W   16  watchdog counter width
// PORTS
//  clk              in   1             clock
//  rst              in   1             reset, synchronous, active-high
//  dma_go_i         in   N_CH          per-channel start pulse
//  dma_abort_i      in   N_CH          per-channel abort pulse
//  dma_done_ack_i   in   N_CH          per-channel done acknowledge
//  tmo_limit_i      in   TMO_W         watchdog limit in cycles; 0 = disabled
//  axi_pend_txn_i   in   N_CH          channel has outstanding AXI txn
//  stream_rd_done_i in   N_CH          read streamer finished
//  stream_wr_done_i in   N_CH          write streamer finished
//  axi_err_i        in   N_CH          AXI error on channel
//  rd_err_i         in   N_CH          read streamer error
//  wr_err_i         in   N_CH          write streamer error
//  err_addr_i       in   N_CH*ADDR_W   faulting address, channel c at [c*ADDR_W +: ADDR_W]
//  err_clr_i        in   1             clear error capture, release ERR channels
//  stream_rd_valid_o out N_CH          read streamer enable
//  stream_wr_valid_o out N_CH          write streamer enable
//  ch_active_o      out  N_CH          channel in RUN
//  ch_done_o        out  N_CH          channel in DONE
//  ch_clear_o       out  N_CH          1-cycle pulse on return to IDLE
//  err_valid_o      out  1             error captured
//  err_ch_o         out  $clog2(N_CH)  channel of captured error; width is 1 when N_CH==1
//  err_src_o        out  2             00 AXI, 01 RD, 10 WR, 11 TIMEOUT
//  err_addr_o       out  ADDR_W        captured address (0 for TIMEOUT)
//  irq_o            out  1             |ch_done_o | err_valid_o
// BEHAVIOUR
//  Reset: all channels IDLE, done flags / counters / capture cleared, every output 0.
//  Per-channel states: IDLE, RUN, DONE, ERR. All transitions are registered.
//   IDLE: go -> RUN. Abort has no effect.
//   RUN:
//    - rd_valid = !rd_done_ff; wr_valid = !wr_done_ff.
//    - done inputs set sticky flags on the next edge.
//    - Exit priority: error > abort > timeout > completion.
//    - Error (any of axi/rd/wr err) -> ERR. Abort -> IDLE.
//    - wdog == tmo_limit_i with limit != 0 -> ERR (src 11).
//    - rd_done_ff & wr_done_ff & !axi_pend_txn_i -> DONE.
//    - Minimum go-to-DONE latency is 3 cycles (done seen in cycle 1).
//   DONE: hold until dma_done_ack_i -> IDLE. Go is ignored.
//   ERR: streamer valids 0; hold until err_clr_i -> IDLE.
//  Go while RUN/DONE/ERR is ignored.
//  Leaving DONE/ERR to IDLE: ch_clear_o=1 in the last DONE/ERR cycle; done flags and wdog cleared.
//  Abort from RUN: ch_clear_o=1 in the abort cycle.
//  Watchdog:
//   - TMO_W-bit counter, 0 on RUN entry, +1 per RUN cycle.
//   - Saturates at all-ones; no wrap.
//   - Restarts at 0 whenever a done input pulses.
//  Error capture:
//   - Loads only while err_valid_o==0.
//   - Lowest-index erroring channel wins.
//   - Within a channel: AXI > RD > WR > TIMEOUT.
//   - Non-winning channels still enter ERR.
//  Same-cycle err_clr_i and new error: capture is cleared and loaded with the new error.
//   The channel reporting the new error ends in ERR; other ERR channels go to IDLE.
//  Errors outside RUN are ignored.
// TESTING
//  1 ch0: go; rd_done cycle 2, wr_done cycle 4, axi_pend low
//    -> ch_done_o[0] rises cycle 6; ack -> clear pulse, then IDLE.
//  2 ch1: go; rd_err_i[1] with addr 0x8000_0040
//    -> ERR; err_valid=1, err_ch=1, src=01, addr=0x8000_0040; irq=1; err_clr -> IDLE + clear.
//  3 ch2+ch3: axi_err same cycle -> err_ch=2, src=00; both in ERR; later ch0 error not captured.
//  4 tmo_limit_i=10, ch0 go, no done -> ERR with src=11, addr=0 at wdog==10; limit 0 -> never times out.
//  5 ch3: go then abort at cycle 5 -> valids drop, clear pulse, IDLE; go again restarts cleanly.
//  6 rst asserted mid-RUN on all channels -> next cycle every output 0, states IDLE.

Source files
------------

// File: rtl/dma_mc_ctrl_fsm.sv
// Multi-channel DMA control FSM.
// One IDLE/RUN/DONE/ERR state machine per channel drives a rd/wr streamer pair,
// tracks sticky streamer-done flags and runs a per-channel watchdog. A single
// shared first-error capture register records the winning error and raises irq.
module dma_mc_ctrl_fsm #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 32,
  parameter int TMO_W  = 16,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          dma_go_i,
  input  logic [N_CH-1:0]          dma_abort_i,
  input  logic [N_CH-1:0]          dma_done_ack_i,
  input  logic [TMO_W-1:0]         tmo_limit_i,
  input  logic [N_CH-1:0]          axi_pend_txn_i,
  input  logic [N_CH-1:0]          stream_rd_done_i,
  input  logic [N_CH-1:0]          stream_wr_done_i,
  input  logic [N_CH-1:0]          axi_err_i,
  input  logic [N_CH-1:0]          rd_err_i,
  input  logic [N_CH-1:0]          wr_err_i,
  input  logic [N_CH*ADDR_W-1:0]   err_addr_i,
  input  logic                     err_clr_i,
  output logic [N_CH-1:0]          stream_rd_valid_o,
  output logic [N_CH-1:0]          stream_wr_valid_o,
  output logic [N_CH-1:0]          ch_active_o,
  output logic [N_CH-1:0]          ch_done_o,
  output logic [N_CH-1:0]          ch_clear_o,
  output logic                     err_valid_o,
  output logic [CH_W-1:0]          err_ch_o,
  output logic [1:0]               err_src_o,
  output logic [ADDR_W-1:0]        err_addr_o,
  output logic                     irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } ch_state_e;

  localparam logic [1:0] SRC_AXI = 2'b00;
  localparam logic [1:0] SRC_RD  = 2'b01;
  localparam logic [1:0] SRC_WR  = 2'b10;
  localparam logic [1:0] SRC_TMO = 2'b11;

  // Per-channel error events (RUN -> ERR this cycle) and their source code
  logic [N_CH-1:0] ch_err_ev;
  logic [1:0]      ch_err_src [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      ch_state_e        state_q, state_d;
      logic             rd_done_q, rd_done_d;
      logic             wr_done_q, wr_done_d;
      logic [TMO_W-1:0] wdog_q, wdog_d;
      logic             clear_c;
      logic             err_ev_c;
      logic [1:0]       err_src_c;
      logic             hw_err;
      logic             tmo_hit;

      // Channel state, sticky done flags and watchdog registers
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q   <= ST_IDLE;
          rd_done_q <= 1'b0;
          wr_done_q <= 1'b0;
          wdog_q    <= '0;
        end else begin
          state_q   <= state_d;
          rd_done_q <= rd_done_d;
          wr_done_q <= wr_done_d;
          wdog_q    <= wdog_d;
        end
      end

      // Next-state logic; exits from RUN ranked error > abort > timeout > completion
      always_comb begin
        state_d   = state_q;
        rd_done_d = rd_done_q;
        wr_done_d = wr_done_q;
        wdog_d    = wdog_q;
        clear_c   = 1'b0;
        err_ev_c  = 1'b0;
        err_src_c = SRC_AXI;
        hw_err    = axi_err_i[gi] | rd_err_i[gi] | wr_err_i[gi];
        tmo_hit   = (tmo_limit_i != '0) && (wdog_q == tmo_limit_i);

        unique case (state_q)
          ST_IDLE: begin
            if (dma_go_i[gi]) begin
              state_d   = ST_RUN;
              rd_done_d = 1'b0;
              wr_done_d = 1'b0;
              wdog_d    = '0;
            end
          end

          ST_RUN: begin
            rd_done_d = rd_done_q | stream_rd_done_i[gi];
            wr_done_d = wr_done_q | stream_wr_done_i[gi];
            // Any streamer progress restarts the watchdog; otherwise count and saturate
            if (stream_rd_done_i[gi] | stream_wr_done_i[gi]) begin
              wdog_d = '0;
            end else if (wdog_q != '1) begin
              wdog_d = wdog_q + TMO_W'(1);
            end

            if (hw_err) begin
              state_d  = ST_ERR;
              err_ev_c = 1'b1;
              if (axi_err_i[gi])     err_src_c = SRC_AXI;
              else if (rd_err_i[gi]) err_src_c = SRC_RD;
              else                   err_src_c = SRC_WR;
            end else if (dma_abort_i[gi]) begin
              state_d   = ST_IDLE;
              clear_c   = 1'b1;
              rd_done_d = 1'b0;
              wr_done_d = 1'b0;
              wdog_d    = '0;
            end else if (tmo_hit) begin
              state_d   = ST_ERR;
              err_ev_c  = 1'b1;
              err_src_c = SRC_TMO;
            end else if (rd_done_q && wr_done_q && !axi_pend_txn_i[gi]) begin
              state_d = ST_DONE;
            end
          end

          ST_DONE: begin
            if (dma_done_ack_i[gi]) begin
              state_d   = ST_IDLE;
              clear_c   = 1'b1;
              rd_done_d = 1'b0;
              wr_done_d = 1'b0;
              wdog_d    = '0;
            end
          end

          ST_ERR: begin
            if (err_clr_i) begin
              state_d   = ST_IDLE;
              clear_c   = 1'b1;
              rd_done_d = 1'b0;
              wr_done_d = 1'b0;
              wdog_d    = '0;
            end
          end

          default: state_d = ST_IDLE;
        endcase
      end

      assign stream_rd_valid_o[gi] = (state_q == ST_RUN) && !rd_done_q;
      assign stream_wr_valid_o[gi] = (state_q == ST_RUN) && !wr_done_q;
      assign ch_active_o[gi]       = (state_q == ST_RUN);
      assign ch_done_o[gi]         = (state_q == ST_DONE);
      assign ch_clear_o[gi]        = clear_c & ~rst;
      assign ch_err_ev[gi]         = err_ev_c;
      assign ch_err_src[gi]        = err_src_c;
    end
  endgenerate

  // Shared first-error capture
  logic              err_valid_q, err_valid_d;
  logic [CH_W-1:0]   err_ch_q, err_ch_d;
  logic [1:0]        err_src_q, err_src_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              win_found;
  logic [CH_W-1:0]   win_ch;
  logic [1:0]        win_src;
  logic [ADDR_W-1:0] win_addr;

  // Capture register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid_q <= 1'b0;
      err_ch_q    <= '0;
      err_src_q   <= '0;
      err_addr_q  <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_ch_q    <= err_ch_d;
      err_src_q   <= err_src_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Pick the lowest-index erroring channel; clear has effect before a same-cycle load
  always_comb begin
    err_valid_d = err_valid_q;
    err_ch_d    = err_ch_q;
    err_src_d   = err_src_q;
    err_addr_d  = err_addr_q;
    win_found   = 1'b0;
    win_ch      = '0;
    win_src     = '0;
    win_addr    = '0;

    // Descending scan so the lowest index is the last (winning) assignment
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_err_ev[i]) begin
        win_found = 1'b1;
        win_ch    = CH_W'(i);
        win_src   = ch_err_src[i];
        win_addr  = (ch_err_src[i] == SRC_TMO) ? '0 : err_addr_i[i*ADDR_W +: ADDR_W];
      end
    end

    if (err_clr_i) begin
      err_valid_d = 1'b0;
      err_ch_d    = '0;
      err_src_d   = '0;
      err_addr_d  = '0;
    end

    if (win_found && (!err_valid_q || err_clr_i)) begin
      err_valid_d = 1'b1;
      err_ch_d    = win_ch;
      err_src_d   = win_src;
      err_addr_d  = win_addr;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_ch_o    = err_ch_q;
  assign err_src_o   = err_src_q;
  assign err_addr_o  = err_addr_q;
  assign irq_o       = (|ch_done_o) | err_valid_q;

endmodule

// File: tb/tb_dma_mc_ctrl_fsm.sv
// Testbench for dma_mc_ctrl_fsm: scenario-driven, expected values queued
// when stimulus is applied and compared when the DUT responds.
module tb_dma_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  go, abort, ack, pend, rdd, wrd, axe, rde, wre;
  logic [15:0] tmo;
  logic [127:0] eaddr;
  logic        eclr;
  logic [3:0]  rdv, wrv, act, dn, clr;
  logic        ev;
  logic [1:0]  ech;
  logic [1:0]  esrc;
  logic [31:0] eo;
  logic        irq;
  logic [57:0] all_o;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb_q[$];

  dma_mc_ctrl_fsm #(.N_CH(4), .ADDR_W(32), .TMO_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .dma_go_i          (go),
    .dma_abort_i       (abort),
    .dma_done_ack_i    (ack),
    .tmo_limit_i       (tmo),
    .axi_pend_txn_i    (pend),
    .stream_rd_done_i  (rdd),
    .stream_wr_done_i  (wrd),
    .axi_err_i         (axe),
    .rd_err_i          (rde),
    .wr_err_i          (wre),
    .err_addr_i        (eaddr),
    .err_clr_i         (eclr),
    .stream_rd_valid_o (rdv),
    .stream_wr_valid_o (wrv),
    .ch_active_o       (act),
    .ch_done_o         (dn),
    .ch_clear_o        (clr),
    .err_valid_o       (ev),
    .err_ch_o          (ech),
    .err_src_o         (esrc),
    .err_addr_o        (eo),
    .irq_o             (irq)
  );

  assign all_o = {rdv, wrv, act, dn, clr, ev, ech, esrc, eo, irq};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs
  task automatic settle();
    #1;
  endtask

  // Launch a channel and run it until DONE or a captured error (bounded at 60 cycles).
  // rd/wr done pulse in the given cycle (go cycle = 0); pend held high for cycles < pend_until.
  task automatic run_ch(input int ch, input int rd_cyc, input int wr_cyc,
                        input int pend_until, output int lat_o);
    int n;
    n = 0;
    go[ch]   = 1'b1;
    pend[ch] = (pend_until > 0);
    do begin
      step();
      n++;
      go[ch]   = 1'b0;
      rdd[ch]  = (n == rd_cyc);
      wrd[ch]  = (n == wr_cyc);
      pend[ch] = (n < pend_until);
    end while (!dn[ch] && !ev && n < 60);
    rdd[ch]  = 1'b0;
    wrd[ch]  = 1'b0;
    pend[ch] = 1'b0;
    lat_o    = n;
    $display("[TB] txn ch%0d: done=%0b err=%0b after %0d cycles", ch, dn[ch], ev, n);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    go = '0; abort = '0; ack = '0; pend = '0; rdd = '0; wrd = '0;
    axe = '0; rde = '0; wre = '0; tmo = '0; eaddr = '0; eclr = 1'b0;

    // Reset state
    step(); step(); step();
    check_val("rst_outputs", 64'(all_o), 64'd0);
    rst = 1'b0;
    step();
    check_val("post_rst_outputs", 64'(all_o), 64'd0);

    // 1: ch0 normal completion, rd_done cycle 2, wr_done cycle 4
    sb_push("t1_done_latency", 64'd6);
    run_ch(0, 2, 4, 0, lat);
    sb_check(64'(lat));
    check_val("t1_done", 64'(dn), 64'h1);
    check_val("t1_irq", 64'(irq), 64'h1);
    check_val("t1_valids", 64'({rdv, wrv, act}), 64'h0);
    go[0] = 1'b1;
    step();
    go[0] = 1'b0;
    check_val("t1_go_in_done", 64'({dn, act}), 64'h10);
    ack[0] = 1'b1;
    settle();
    check_val("t1_clear", 64'(clr), 64'h1);
    step();
    ack[0] = 1'b0;
    settle();
    check_val("t1_idle", 64'({dn, clr, irq}), 64'h0);

    // Error while IDLE is ignored
    rde[0] = 1'b1;
    step();
    rde[0] = 1'b0;
    check_val("idle_err_ignored", 64'(ev), 64'h0);

    // 2: ch1 read error with address
    go[1] = 1'b1;
    step();
    go[1] = 1'b0;
    check_val("t2_run", 64'({act, rdv, wrv}), 64'h222);
    eaddr[63:32] = 32'h8000_0040;
    rde[1] = 1'b1;
    sb_push("t2_err_valid", 64'h1);
    sb_push("t2_err_ch", 64'h1);
    sb_push("t2_err_src", 64'h1);
    sb_push("t2_err_addr", 64'h8000_0040);
    sb_push("t2_irq", 64'h1);
    step();
    rde[1] = 1'b0;
    sb_check(64'(ev));
    sb_check(64'(ech));
    sb_check(64'(esrc));
    sb_check(64'(eo));
    sb_check(64'(irq));
    $display("[TB] txn ch1: rd error captured ch=%0d src=%0d addr=0x%0h", ech, esrc, eo);
    check_val("t2_err_state", 64'({act, rdv, wrv}), 64'h0);
    eclr = 1'b1;
    settle();
    check_val("t2_clear", 64'(clr), 64'h2);
    step();
    eclr = 1'b0;
    settle();
    check_val("t2_released", 64'({ev, irq, clr}), 64'h0);

    // 3: ch2+ch3 simultaneous AXI errors, lowest index wins
    go = 4'b1100;
    step();
    go = '0;
    eaddr[95:64]  = 32'h2222_0000;
    eaddr[127:96] = 32'h3333_0000;
    axe = 4'b1100;
    sb_push("t3_err_ch", 64'h2);
    sb_push("t3_err_src", 64'h0);
    sb_push("t3_err_addr", 64'h2222_0000);
    step();
    axe = '0;
    sb_check(64'(ech));
    sb_check(64'(esrc));
    sb_check(64'(eo));
    $display("[TB] txn ch2+ch3: axi errors, captured ch=%0d", ech);
    check_val("t3_both_err", 64'(act), 64'h0);
    go[3] = 1'b1;
    step();
    go[3] = 1'b0;
    check_val("t3_go_in_err", 64'(act), 64'h0);
    go[0] = 1'b1;
    step();
    go[0] = 1'b0;
    eaddr[31:0] = 32'h0BAD_0000;
    wre[0] = 1'b1;
    step();
    wre[0] = 1'b0;
    check_val("t3_no_recapture", 64'({ech, esrc, eo}), 64'h8_2222_0000);
    check_val("t3_ch0_err", 64'({act, rdv}), 64'h0);
    eclr = 1'b1;
    settle();
    check_val("t3_clear_all", 64'(clr), 64'hD);
    step();
    eclr = 1'b0;
    check_val("t3_released", 64'({ev, act}), 64'h0);

    // Same-cycle clear and new error
    go = 4'b0011;
    step();
    go = '0;
    rde[0] = 1'b1;
    step();
    rde[0] = 1'b0;
    check_val("sc_first", 64'({ech, esrc}), 64'h1);
    eaddr[63:32] = 32'h0000_1234;
    wre[1] = 1'b1;
    eclr = 1'b1;
    settle();
    check_val("sc_clear", 64'(clr), 64'h1);
    step();
    wre[1] = 1'b0;
    eclr = 1'b0;
    check_val("sc_reload", 64'({ev, ech, esrc, eo}), 64'h1_6_0000_1234);
    go[0] = 1'b1;
    step();
    go[0] = 1'b0;
    check_val("sc_ch0_idle", 64'(act), 64'h1);
    abort[0] = 1'b1;
    settle();
    check_val("sc_abort_clear", 64'(clr), 64'h1);
    step();
    abort[0] = 1'b0;
    eclr = 1'b1;
    settle();
    check_val("sc_ch1_err_clear", 64'(clr), 64'h2);
    step();
    eclr = 1'b0;
    abort[2] = 1'b1;
    settle();
    check_val("idle_abort_ignored", 64'(clr), 64'h0);
    step();
    abort[2] = 1'b0;

    // 4: watchdog
    tmo = 16'd10;
    eaddr[31:0] = 32'hDEAD_BEEF;
    sb_push("t4_tmo_latency", 64'd12);
    run_ch(0, -1, -1, 0, lat);
    sb_check(64'(lat));
    check_val("t4_tmo_capture", 64'({ev, ech, esrc, eo}), 64'h1_3_0000_0000);
    eclr = 1'b1;
    step();
    eclr = 1'b0;
    sb_push("t4_tmo_restart_latency", 64'd17);
    run_ch(0, 5, -1, 0, lat);
    sb_check(64'(lat));
    check_val("t4_restart_src", 64'(esrc), 64'h3);
    eclr = 1'b1;
    step();
    eclr = 1'b0;
    tmo = 16'd0;
    sb_push("t4_disabled_latency", 64'd60);
    run_ch(0, -1, -1, 0, lat);
    sb_check(64'(lat));
    check_val("t4_disabled_state", 64'({act[0], ev}), 64'h2);
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;

    // 5: ch3 abort at cycle 5, then a clean restart with minimum latency
    go[3] = 1'b1;
    step();
    go[3] = 1'b0;
    step(); step(); step(); step();
    abort[3] = 1'b1;
    settle();
    check_val("t5_abort_cycle", 64'({clr, rdv, wrv}), 64'h888);
    step();
    abort[3] = 1'b0;
    settle();
    check_val("t5_after_abort", 64'({clr, rdv, wrv, act}), 64'h0);
    sb_push("t5_min_latency", 64'd3);
    run_ch(3, 1, 1, 0, lat);
    sb_check(64'(lat));
    ack[3] = 1'b1;
    step();
    ack[3] = 1'b0;

    // Outstanding AXI transactions hold off completion
    sb_push("pend_latency", 64'd5);
    run_ch(2, 1, 1, 4, lat);
    sb_check(64'(lat));
    ack[2] = 1'b1;
    step();
    ack[2] = 1'b0;
    check_val("pend_idle", 64'(dn), 64'h0);

    // 6: reset mid-RUN
    go = 4'hF;
    step();
    go = '0;
    step();
    check_val("t6_running", 64'(act), 64'hF);
    rst = 1'b1;
    step();
    settle();
    check_val("t6_reset_outputs", 64'(all_o), 64'd0);
    rst = 1'b0;
    step();
    check_val("t6_idle_after", 64'(all_o), 64'd0);

    check_val("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
